// File: rtl/gray_ptr_sync.sv
// gray_ptr_sync
//   Multi-stage synchronizer for a Gray-coded FIFO pointer arriving from
//   another clock domain. Besides the raw synchronized pointer it provides a
//   registered binary copy, a one-cycle change strobe, and a sticky flag for
//   synchronized steps that moved more than one bit. The flag indicates a
//   broken source or a broken crossing. The strobe and the flag only start
//   working once the chain has been flushed of reset values.
//
// Parameters
//   ADDR_SIZE   address bits; pointers are ADDR_SIZE+1 wide (wrap bit on top)
//   STAGES      synchronizer depth, 2..4
// Ports
//   CLK           destination clock, rising edge
//   RST_n         asynchronous active-low reset
//   IN_Address    Gray pointer from the source domain (asynchronous)
//   ERR_Clear     synchronous clear of ERR_MultiBit
//   OUT_Address   synchronized Gray pointer (last stage)
//   OUT_Binary    registered binary form of OUT_Address
//   OUT_Changed   one-cycle strobe when OUT_Binary takes a new value
//   OUT_Valid     high once the chain holds only post-reset samples
//   ERR_MultiBit  sticky multi-bit-step error
module gray_ptr_sync #(
  parameter int ADDR_SIZE = 6,
  parameter int STAGES    = 2
) (
  input  logic                 CLK,
  input  logic                 RST_n,
  input  logic [ADDR_SIZE:0]   IN_Address,
  input  logic                 ERR_Clear,
  output logic [ADDR_SIZE:0]   OUT_Address,
  output logic [ADDR_SIZE:0]   OUT_Binary,
  output logic                 OUT_Changed,
  output logic                 OUT_Valid,
  output logic                 ERR_MultiBit
);

  localparam int W  = ADDR_SIZE + 1;
  localparam int CW = $clog2(STAGES + 2);
  localparam logic [CW-1:0] VCNT = CW'(STAGES + 1);

  if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
    $error("gray_ptr_sync: STAGES must be in 2..4");
  end

  // sync[0] samples the asynchronous input; sync[STAGES-1] is the output.
  logic [STAGES-1:0][W-1:0] sync;
  logic [W-1:0]             prev_gray;
  logic [W-1:0]             diff;
  logic [CW-1:0]            vcnt;
  logic                     multi;

  function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--)
      b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  assign OUT_Address = sync[STAGES-1];
  assign OUT_Valid   = (vcnt == VCNT);

  // More than one bit set: clearing the lowest set bit leaves something.
  assign diff  = OUT_Address ^ prev_gray;
  assign multi = (diff & (diff - W'(1))) != '0;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      sync      <= '0;
      prev_gray <= '0;
    end else begin
      sync      <= {sync[STAGES-2:0], IN_Address};
      prev_gray <= OUT_Address;
    end
  end

  // Counts edges since reset release; the chain is flushed after STAGES+1.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n)
      vcnt <= '0;
    else if (vcnt != VCNT)
      vcnt <= vcnt + CW'(1);
  end

  // Data keeps flowing before valid; only the strobe and error are gated.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      OUT_Binary   <= '0;
      OUT_Changed  <= 1'b0;
      ERR_MultiBit <= 1'b0;
    end else begin
      OUT_Binary  <= gray2bin(OUT_Address);
      OUT_Changed <= OUT_Valid && (diff != '0);
      // A new error outranks a clear issued on the same edge.
      if (OUT_Valid && multi)
        ERR_MultiBit <= 1'b1;
      else if (ERR_Clear)
        ERR_MultiBit <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gray_ptr_sync.sv
// Directed bench for gray_ptr_sync. Three instances (STAGES = 2, 3, 4) share
// the same stimulus. Detailed data checks use the STAGES=3 instance. Valid
// timing and pre-valid suppression are checked on all three.
module tb_gray_ptr_sync;

  localparam int A = 6;
  localparam int W = A + 1;

  logic         CLK, RST_n, ERR_Clear;
  logic [W-1:0] IN_Address;

  logic [W-1:0] addr2, bin2, addr3, bin3, addr4, bin4;
  logic         chg2, vld2, err2, chg3, vld3, err3, chg4, vld4, err4;

  gray_ptr_sync #(.ADDR_SIZE(A), .STAGES(2)) u_s2 (
    .CLK(CLK), .RST_n(RST_n), .IN_Address(IN_Address), .ERR_Clear(ERR_Clear),
    .OUT_Address(addr2), .OUT_Binary(bin2), .OUT_Changed(chg2),
    .OUT_Valid(vld2), .ERR_MultiBit(err2));

  gray_ptr_sync #(.ADDR_SIZE(A), .STAGES(3)) u_s3 (
    .CLK(CLK), .RST_n(RST_n), .IN_Address(IN_Address), .ERR_Clear(ERR_Clear),
    .OUT_Address(addr3), .OUT_Binary(bin3), .OUT_Changed(chg3),
    .OUT_Valid(vld3), .ERR_MultiBit(err3));

  gray_ptr_sync #(.ADDR_SIZE(A), .STAGES(4)) u_s4 (
    .CLK(CLK), .RST_n(RST_n), .IN_Address(IN_Address), .ERR_Clear(ERR_Clear),
    .OUT_Address(addr4), .OUT_Binary(bin4), .OUT_Changed(chg4),
    .OUT_Valid(vld4), .ERR_MultiBit(err4));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int npass = 0;
  int ntot  = 0;

  typedef struct {
    logic [W-1:0] in;
    logic         clr;
    logic [W-1:0] addr;
    logic [W-1:0] bin;
    logic         chg;
    logic         err;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic hold_and_clear(input int n);
    for (int i = 0; i < n; i++) step();
    ERR_Clear = 1'b1;
    step();
    ERR_Clear = 1'b0;
    chk("quiet_clear", 32'(err3), 32'd0);
  endtask

  initial begin
    // {in, clr, addr, bin, chg, err} for STAGES=3, starting from settled 0.
    tbl[0]  = '{7'd1, 1'b0, 7'd0, 7'd0, 1'b0, 1'b0};
    tbl[1]  = '{7'd1, 1'b0, 7'd0, 7'd0, 1'b0, 1'b0};
    tbl[2]  = '{7'd1, 1'b0, 7'd1, 7'd0, 1'b0, 1'b0};
    tbl[3]  = '{7'd1, 1'b0, 7'd1, 7'd1, 1'b1, 1'b0};
    tbl[4]  = '{7'd1, 1'b0, 7'd1, 7'd1, 1'b0, 1'b0};
    tbl[5]  = '{7'd3, 1'b0, 7'd1, 7'd1, 1'b0, 1'b0};
    tbl[6]  = '{7'd2, 1'b0, 7'd1, 7'd1, 1'b0, 1'b0};
    tbl[7]  = '{7'd2, 1'b0, 7'd3, 7'd1, 1'b0, 1'b0};
    tbl[8]  = '{7'd2, 1'b0, 7'd2, 7'd2, 1'b1, 1'b0};
    tbl[9]  = '{7'd2, 1'b0, 7'd2, 7'd3, 1'b1, 1'b0};
    tbl[10] = '{7'd2, 1'b0, 7'd2, 7'd3, 1'b0, 1'b0};
    tbl[11] = '{7'd5, 1'b0, 7'd2, 7'd3, 1'b0, 1'b0};
    tbl[12] = '{7'd5, 1'b0, 7'd2, 7'd3, 1'b0, 1'b0};
    tbl[13] = '{7'd5, 1'b0, 7'd5, 7'd3, 1'b0, 1'b0};
    tbl[14] = '{7'd5, 1'b0, 7'd5, 7'd6, 1'b1, 1'b1};
    tbl[15] = '{7'd5, 1'b1, 7'd5, 7'd6, 1'b0, 1'b0};
    tbl[16] = '{7'd5, 1'b0, 7'd5, 7'd6, 1'b0, 1'b0};

    RST_n = 1'b1; ERR_Clear = 1'b0; IN_Address = '0;
    #3 RST_n = 1'b0;
    #1;
    chk("rst_addr", 32'(addr3), 32'd0);
    chk("rst_bin",  32'(bin3),  32'd0);
    chk("rst_chg",  32'(chg3),  32'd0);
    chk("rst_vld",  32'(vld3),  32'd0);
    chk("rst_err",  32'(err3),  32'd0);

    // Release mid-cycle and drive 2-bit jumps before edges 1..3.
    @(posedge CLK); #1;
    IN_Address = 7'd3;
    RST_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      IN_Address = (k == 2) ? 7'd0 : 7'd3;
      step();
      chk("vld_s2", 32'(vld2), 32'(k >= 3));
      chk("vld_s3", 32'(vld3), 32'(k >= 4));
      chk("vld_s4", 32'(vld4), 32'(k >= 5));
      if (k <= 3) chk("pre_s2", 32'({chg2, err2}), 32'd0);
      if (k <= 4) chk("pre_s3", 32'({chg3, err3}), 32'd0);
      if (k <= 5) chk("pre_s4", 32'({chg4, err4}), 32'd0);
    end

    // Settle at 0 with the error flag cleared, then run the table.
    IN_Address = '0;
    hold_and_clear(6);
    for (int i = 0; i < 17; i++) begin
      IN_Address = tbl[i].in;
      ERR_Clear  = tbl[i].clr;
      step();
      chk($sformatf("tbl%0d_addr", i), 32'(addr3), 32'(tbl[i].addr));
      chk($sformatf("tbl%0d_bin", i),  32'(bin3),  32'(tbl[i].bin));
      chk($sformatf("tbl%0d_chg", i),  32'(chg3),  32'(tbl[i].chg));
      chk($sformatf("tbl%0d_err", i),  32'(err3),  32'(tbl[i].err));
    end
    ERR_Clear = 1'b0;

    // 2-bit jump 0 -> 3, quiet clear, then a clear coincident with a new error.
    IN_Address = '0;
    hold_and_clear(6);
    IN_Address = 7'd3;
    for (int k = 1; k <= 9; k++) begin
      if (k == 6) IN_Address = 7'd0;
      ERR_Clear = (k == 5 || k == 9);
      step();
      if (k == 3) chk("jump_err_early", 32'(err3), 32'd0);
      if (k == 4) begin
        chk("jump_bin", 32'(bin3), 32'd2);
        chk("jump_chg", 32'(chg3), 32'd1);
        chk("jump_err", 32'(err3), 32'd1);
      end
      if (k == 5) chk("clear_quiet", 32'(err3), 32'd0);
      if (k == 9) begin
        chk("set_beats_clear", 32'(err3), 32'd1);
        chk("set_beats_clear_bin", 32'(bin3), 32'd0);
      end
    end
    ERR_Clear = 1'b0;

    // Full Gray walk 1..127 then wrap to 0, one step per cycle.
    hold_and_clear(3);
    for (int m = 1; m <= 131; m++) begin
      if (m <= 127) IN_Address = W'(m ^ (m >> 1));
      else          IN_Address = '0;
      step();
      if (m >= 4) begin
        chk($sformatf("walk%0d_bin", m - 3), 32'(bin3), 32'((m - 3) & 127));
        chk($sformatf("walk%0d_chg", m - 3), 32'(chg3), 32'd1);
        chk($sformatf("walk%0d_err", m - 3), 32'(err3), 32'd0);
      end
    end
    for (int m = 0; m < 10; m++) begin
      step();
      chk("stable_chg", 32'(chg3), 32'd0);
    end

    // Mid-stream reset with strobe and error both high.
    IN_Address = 7'd3;
    for (int k = 0; k < 4; k++) step();
    chk("mid_pre_chg", 32'(chg3), 32'd1);
    chk("mid_pre_err", 32'(err3), 32'd1);
    #2 RST_n = 1'b0;
    #1;
    chk("mid_addr", 32'(addr3), 32'd0);
    chk("mid_bin",  32'(bin3),  32'd0);
    chk("mid_chg",  32'(chg3),  32'd0);
    chk("mid_err",  32'(err3),  32'd0);
    chk("mid_vld",  32'({vld2, vld3, vld4}), 32'd0);
    @(negedge CLK);
    RST_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("mid_vld_s2", 32'(vld2), 32'(k >= 3));
      chk("mid_vld_s3", 32'(vld3), 32'(k >= 4));
      chk("mid_vld_s4", 32'(vld4), 32'(k >= 5));
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/gray_ptr_sync.md
# gray_ptr_sync

Parametrised N-stage synchronizer for Gray-coded FIFO pointers crossing into the local clock domain. It replaces the fixed two-flop pointer synchronizer with a configurable stage count. It adds a registered Gray-to-binary output, a change strobe and a sticky multi-bit-transition error flag, all gated by a post-reset valid indicator. It sits on both sides of the asynchronous FIFO: write pointer into the read domain, and read pointer into the write domain.

## Interface
- ADDR_SIZE, 6, address bits; pointer width is ADDR_SIZE+1 (includes wrap bit)
- STAGES, 2, synchronizer depth; legal range 2..4; out-of-range values are an elaboration error

- CLK  in  1  destination-domain clock, rising edge
- RST_n  in  1  asynchronous active-low reset
- IN_Address  in  ADDR_SIZE+1  Gray pointer from source domain; asynchronous to CLK
- ERR_Clear  in  1  synchronous clear of ERR_MultiBit
- OUT_Address  out  ADDR_SIZE+1  synchronized Gray pointer (last stage)
- OUT_Binary  out  ADDR_SIZE+1  registered binary equivalent of OUT_Address
- OUT_Changed  out  1  one-cycle strobe; OUT_Binary took a new value this cycle
- OUT_Valid  out  1  high once the pipeline holds only post-reset samples
- ERR_MultiBit  out  1  sticky; successive synchronized Gray values differed in more than one bit

## Operation
- Stage chain s[0..STAGES-1], each ADDR_SIZE+1 wide: s[0] <= IN_Address, s[i] <= s[i-1]; OUT_Address = s[STAGES-1].
- prev_gray <= OUT_Address every cycle. This is an internal register holding the previous OUT_Address.
- OUT_Binary <= gray2bin(OUT_Address), where b[MSB] = g[MSB] and b[i] = b[i+1] ^ g[i]. Pure XOR prefix; no arithmetic.
- OUT_Changed <= OUT_Valid_d && (OUT_Address != prev_gray). OUT_Valid_d is the value of OUT_Valid before the edge.
- Error set condition: OUT_Valid_d && popcount(OUT_Address ^ prev_gray) > 1.
- ERR_MultiBit next value: set condition ? 1 : (ERR_Clear ? 0 : ERR_MultiBit). Set wins over a simultaneous clear.
- Valid counter: counts rising edges after reset deassertion, saturating at STAGES+1. OUT_Valid = (count == STAGES+1) and stays high until the next reset.
- While OUT_Valid is low, OUT_Changed and error setting are suppressed. Data outputs still update.
- Wrap-around is a normal single-bit Gray step. Example: all-ones-binary (Gray 1000…0) to zero (Gray 0…0) raises OUT_Changed only, with no error.

## Timing
- Reset (RST_n low, asynchronous): all stages, prev_gray, OUT_Address, OUT_Binary, OUT_Changed, OUT_Valid, ERR_MultiBit and the valid counter clear to 0 immediately.
- Latency, IN_Address to OUT_Address: STAGES rising edges.
- Latency, IN_Address to OUT_Binary and OUT_Changed: STAGES+1 rising edges.
- OUT_Changed is high for exactly one cycle per distinct synchronized value.
- A stable input gives no strobe. Back-to-back input steps on consecutive cycles give consecutive strobes.
- OUT_Valid first rises at edge STAGES+1 after RST_n deasserts.
- Reset mid-operation: every output returns to 0 asynchronously and the valid count restarts from 0. Any pending strobe or error is discarded.
- ERR_Clear takes effect on the next edge. It is ignored while the set condition is true.

## Test plan
- Reset values and valid timing: assert RST_n low mid-cycle with nonzero pipeline contents -> all outputs 0 at once. Release RST_n -> OUT_Valid rises at edge 3 for STAGES=2 and at edge 5 for STAGES=4.
- Latency, STAGES=3, ADDR_SIZE=6, after OUT_Valid: step IN_Address from Gray 0000000 to 0000001 -> OUT_Address = 0000001 after 3 edges. At edge 4, OUT_Binary = 1 and OUT_Changed pulses once.
- Full Gray sequence 0..127 and wrap to 0, one step per cycle: OUT_Binary follows 0..127 then 0, with OUT_Changed high each cycle and ERR_MultiBit staying 0. Then hold input stable for 10 cycles -> OUT_Changed stays 0.
- Multi-bit jump after valid: IN_Address 0000000 to 0000011 (2-bit change) -> ERR_MultiBit = 1 at edge STAGES+1, and OUT_Binary = 2. Pulse ERR_Clear on a quiet cycle -> 0 next edge. Drive ERR_Clear coincident with a second 2-bit jump -> flag stays 1.
- Pre-valid suppression: change IN_Address every cycle with 2-bit jumps during the first STAGES cycles after reset -> OUT_Changed = 0 and ERR_MultiBit = 0 until OUT_Valid is high.
- Mid-stream reset: assert RST_n while OUT_Changed = 1 and ERR_MultiBit = 1 -> both clear immediately. OUT_Valid is low until STAGES+1 edges after release.
